// File: rtl/a2d_seq_mc_if.sv
// ---------------------------------------------------------------------------
// a2d_seq_mc_if
// Bundles the host-side control/status signals and the four SPI lines of the
// multi-channel A2D sequencer.
//   en, ch_mask        : run enable and per-slot enable mask (host -> seq)
//   result, res_vld    : packed per-slot results and update strobes
//   sweep_done, busy   : sweep completion pulse and activity flag
//   SS_n, SCLK, MOSI   : SPI lines driven towards the ADC
//   MISO               : SPI data returned by the ADC
// The sequencer connects through the master modport; the host/ADC side
// through the slave modport.
// ---------------------------------------------------------------------------
interface a2d_seq_mc_if #(
  parameter int NUM_CH = 4,
  parameter int RES_W  = 12
);
  logic                    en;
  logic [NUM_CH-1:0]       ch_mask;
  logic                    MISO;
  logic                    SS_n;
  logic                    SCLK;
  logic                    MOSI;
  logic [NUM_CH*RES_W-1:0] result;
  logic [NUM_CH-1:0]       res_vld;
  logic                    sweep_done;
  logic                    busy;

  modport master (
    input  en, ch_mask, MISO,
    output SS_n, SCLK, MOSI, result, res_vld, sweep_done, busy
  );

  modport slave (
    output en, ch_mask, MISO,
    input  SS_n, SCLK, MOSI, result, res_vld, sweep_done, busy
  );
endinterface

// File: rtl/a2d_seq_mc.sv
// ---------------------------------------------------------------------------
// a2d_seq_mc_spi
// 16-bit SPI master (mode 0, MSB first). A one-clock wrt starts a transaction
// sending cmd; done pulses for one clock as SS_n returns high, at which point
// rd_data holds the low RD_W bits of the word shifted in from MISO.
// SCLK period is 8 clk cycles.
// Ports: clk, rst_n, wrt, cmd[15:0], done, rd_data[RD_W-1:0], SS_n, SCLK,
//        MOSI, MISO.
// ---------------------------------------------------------------------------
module a2d_seq_mc_spi #(
  parameter int RD_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrt,
  input  logic [15:0]     cmd,
  output logic            done,
  output logic [RD_W-1:0] rd_data,
  output logic            SS_n,
  output logic            SCLK,
  output logic            MOSI,
  input  logic            MISO
);
  typedef enum logic [1:0] {
    SP_IDLE  = 2'd0,
    SP_SHIFT = 2'd1,
    SP_BACK  = 2'd2
  } sp_state_e;

  sp_state_e   sp_r;
  sp_state_e   sp_nxt;
  logic [2:0]  div_r;
  logic [3:0]  bit_r;
  logic [15:0] shft_r;
  logic        miso_r;
  logic        ss_n_r;
  logic        sclk_r;
  logic        done_r;

  // SPI state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r <= SP_IDLE;
    end else begin
      sp_r <= sp_nxt;
    end
  end

  // SPI next-state logic
  always_comb begin
    sp_nxt = sp_r;
    case (sp_r)
      SP_IDLE: begin
        if (wrt) begin
          sp_nxt = SP_SHIFT;
        end else begin
          sp_nxt = SP_IDLE;
        end
      end
      SP_SHIFT: begin
        if ((div_r == 3'd7) && (bit_r == 4'd15)) begin
          sp_nxt = SP_BACK;
        end else begin
          sp_nxt = SP_SHIFT;
        end
      end
      SP_BACK: begin
        if (div_r == 3'd3) begin
          sp_nxt = SP_IDLE;
        end else begin
          sp_nxt = SP_BACK;
        end
      end
      default: sp_nxt = SP_IDLE;
    endcase
  end

  // SPI datapath: SCLK rises at div 3 (MISO sampled), falls at div 7 (shift)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r  <= 3'd0;
      bit_r  <= 4'd0;
      shft_r <= 16'h0000;
      miso_r <= 1'b0;
      ss_n_r <= 1'b1;
      sclk_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (sp_r)
        SP_IDLE: begin
          if (wrt) begin
            shft_r <= cmd;
            ss_n_r <= 1'b0;
            div_r  <= 3'd0;
            bit_r  <= 4'd0;
          end
        end
        SP_SHIFT: begin
          div_r <= div_r + 3'd1;
          if (div_r == 3'd3) begin
            sclk_r <= 1'b1;
            miso_r <= MISO;
          end else if (div_r == 3'd7) begin
            sclk_r <= 1'b0;
            shft_r <= {shft_r[14:0], miso_r};
            bit_r  <= bit_r + 4'd1;
          end
        end
        SP_BACK: begin
          div_r <= div_r + 3'd1;
          if (div_r == 3'd3) begin
            ss_n_r <= 1'b1;
            done_r <= 1'b1;
          end
        end
        default: begin
          ss_n_r <= 1'b1;
          sclk_r <= 1'b0;
        end
      endcase
    end
  end

  assign SS_n    = ss_n_r;
  assign SCLK    = sclk_r;
  assign MOSI    = shft_r[15];
  assign done    = done_r;
  assign rd_data = shft_r[RD_W-1:0];
endmodule

// ---------------------------------------------------------------------------
// a2d_seq_mc
// Multi-channel A2D conversion sequencer. Round-robins over the enabled
// channel slots, issuing two identical SPI commands per conversion (the first
// reply is discarded, the second carries the sample), optionally averages
// 2^AVG_LOG2 samples per slot and publishes per-slot results.
// Ports: clk, rst_n (async active-low), bus (a2d_seq_mc_if.master):
//   en, ch_mask in; result, res_vld, sweep_done, busy out; SPI SS_n, SCLK,
//   MOSI out, MISO in.
// ---------------------------------------------------------------------------
module a2d_seq_mc #(
  parameter int                  NUM_CH   = 4,
  parameter logic [3*NUM_CH-1:0] CH_MAP   = {3'd4, 3'd3, 3'd1, 3'd0},
  parameter int                  RES_W    = 12,
  parameter int                  PACE     = 16383,
  parameter int                  AVG_LOG2 = 0
) (
  input logic          clk,
  input logic          rst_n,
  a2d_seq_mc_if.master bus
);
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PACE_W = (PACE > 1) ? $clog2(PACE) : 1;
  localparam int ACC_W  = RES_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [PACE_W-1:0] PACE_LD  = PACE_W'(PACE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PACE1 = 3'd1,
    ST_CMD   = 3'd2,
    ST_PACE2 = 3'd3,
    ST_RD    = 3'd4,
    ST_ACC   = 3'd5
  } state_e;

  state_e                  state_r;
  state_e                  state_nxt;
  logic [PTR_W-1:0]        slot_r;
  logic [PTR_W-1:0]        slot_nxt;
  logic [PACE_W-1:0]       pace_cnt_r;
  logic [RES_W-1:0]        sample_r;
  logic [ACC_W-1:0]        acc_r [NUM_CH];
  logic [CNT_W-1:0]        samp_cnt_r [NUM_CH];
  logic [NUM_CH*RES_W-1:0] result_r;
  logic [NUM_CH-1:0]       res_vld_r;
  logic                    sweep_done_r;
  logic                    busy_r;

  logic                    pace_ld_s;
  logic                    wrt_s;
  logic                    smp_ld_s;
  logic                    acc_step_s;
  logic                    spi_done_s;
  logic [RES_W-1:0]        spi_rd_s;
  logic [15:0]             spi_cmd_s;
  logic [PTR_W-1:0]        inc_slot_s;
  logic [PTR_W-1:0]        next_slot_s;
  logic                    next_ok_s;
  logic                    wrap_s;
  logic                    publish_s;
  logic [ACC_W-1:0]        acc_sum_s;
  logic [RES_W-1:0]        pub_val_s;
  logic                    ss_n_s;
  logic                    sclk_s;
  logic                    mosi_s;

  // First enabled slot at or after start, wrapping; returns start if none.
  function automatic logic [PTR_W-1:0] find_slot(input logic [NUM_CH-1:0] mask,
                                                 input logic [PTR_W-1:0]  start);
    logic [PTR_W:0]   nxt;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] sel;
    logic             found;
    sel   = start;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      nxt = {1'b0, start} + (PTR_W + 1)'(i);
      if (nxt >= (PTR_W + 1)'(NUM_CH)) begin
        nxt = nxt - (PTR_W + 1)'(NUM_CH);
      end else begin
        nxt = nxt;
      end
      idx = nxt[PTR_W-1:0];
      if (!found && mask[idx]) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  // ADC channel number mapped to a slot.
  function automatic logic [2:0] slot_ch(input logic [PTR_W-1:0] s);
    logic [2:0] ch;
    ch = 3'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s == PTR_W'(i)) begin
        ch = CH_MAP[3*i +: 3];
      end else begin
        ch = ch;
      end
    end
    return ch;
  endfunction

  a2d_seq_mc_spi #(.RD_W(RES_W)) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt_s),
    .cmd     (spi_cmd_s),
    .done    (spi_done_s),
    .rd_data (spi_rd_s),
    .SS_n    (ss_n_s),
    .SCLK    (sclk_s),
    .MOSI    (mosi_s),
    .MISO    (bus.MISO)
  );

  // Slot bookkeeping used in ACC: successor slot, wrap detect, publish decision
  always_comb begin
    spi_cmd_s = {2'b00, slot_ch(slot_r), 11'h000};
    if (slot_r == PTR_W'(NUM_CH - 1)) begin
      inc_slot_s = {PTR_W{1'b0}};
    end else begin
      inc_slot_s = slot_r + PTR_W'(1);
    end
    next_ok_s   = |bus.ch_mask;
    next_slot_s = find_slot(bus.ch_mask, inc_slot_s);
    // successor at or below the current index means the sweep wrapped
    wrap_s      = (next_slot_s <= slot_r);
    publish_s   = (samp_cnt_r[slot_r] == CNT_LAST);
    acc_sum_s   = acc_r[slot_r] + ACC_W'(sample_r);
    pub_val_s   = acc_sum_s[ACC_W-1:AVG_LOG2];
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Sequencer next-state and control strobes
  always_comb begin
    state_nxt  = state_r;
    slot_nxt   = slot_r;
    pace_ld_s  = 1'b0;
    wrt_s      = 1'b0;
    smp_ld_s   = 1'b0;
    acc_step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.en && next_ok_s) begin
          slot_nxt  = find_slot(bus.ch_mask, slot_r);
          pace_ld_s = 1'b1;
          state_nxt = ST_PACE1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PACE1: begin
        if (pace_cnt_r == {PACE_W{1'b0}}) begin
          wrt_s     = 1'b1;
          state_nxt = ST_CMD;
        end else begin
          state_nxt = ST_PACE1;
        end
      end
      ST_CMD: begin
        if (spi_done_s) begin
          pace_ld_s = 1'b1;
          state_nxt = ST_PACE2;
        end else begin
          state_nxt = ST_CMD;
        end
      end
      ST_PACE2: begin
        if (pace_cnt_r == {PACE_W{1'b0}}) begin
          wrt_s     = 1'b1;
          state_nxt = ST_RD;
        end else begin
          state_nxt = ST_PACE2;
        end
      end
      ST_RD: begin
        if (spi_done_s) begin
          smp_ld_s  = 1'b1;
          state_nxt = ST_ACC;
        end else begin
          state_nxt = ST_RD;
        end
      end
      ST_ACC: begin
        acc_step_s = 1'b1;
        // with an empty mask the pointer still moves past the finished slot
        if (next_ok_s) begin
          slot_nxt = next_slot_s;
        end else begin
          slot_nxt = inc_slot_s;
        end
        if (bus.en && next_ok_s) begin
          pace_ld_s = 1'b1;
          state_nxt = ST_PACE1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pace counter, slot pointer, sample capture and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pace_cnt_r <= {PACE_W{1'b0}};
      slot_r     <= {PTR_W{1'b0}};
      sample_r   <= {RES_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      slot_r <= slot_nxt;
      busy_r <= (state_nxt != ST_IDLE);
      if (pace_ld_s) begin
        pace_cnt_r <= PACE_LD;
      end else if (((state_r == ST_PACE1) || (state_r == ST_PACE2)) &&
                   (pace_cnt_r != {PACE_W{1'b0}})) begin
        pace_cnt_r <= pace_cnt_r - PACE_W'(1);
      end
      if (smp_ld_s) begin
        sample_r <= spi_rd_s;
      end
    end
  end

  // Per-slot accumulation, result publication and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_r[i]      <= {ACC_W{1'b0}};
        samp_cnt_r[i] <= {CNT_W{1'b0}};
      end
      result_r     <= {(NUM_CH*RES_W){1'b0}};
      res_vld_r    <= {NUM_CH{1'b0}};
      sweep_done_r <= 1'b0;
    end else begin
      sweep_done_r <= acc_step_s && publish_s && wrap_s;
      for (int i = 0; i < NUM_CH; i++) begin
        res_vld_r[i] <= acc_step_s && publish_s && (slot_r == PTR_W'(i));
        if (acc_step_s && (slot_r == PTR_W'(i))) begin
          if (publish_s) begin
            acc_r[i]                   <= {ACC_W{1'b0}};
            samp_cnt_r[i]              <= {CNT_W{1'b0}};
            result_r[RES_W*i +: RES_W] <= pub_val_s;
          end else begin
            acc_r[i]      <= acc_sum_s;
            samp_cnt_r[i] <= samp_cnt_r[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.SS_n       = ss_n_s;
  assign bus.SCLK       = sclk_s;
  assign bus.MOSI       = mosi_s;
  assign bus.result     = result_r;
  assign bus.res_vld    = res_vld_r;
  assign bus.sweep_done = sweep_done_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_a2d_seq_mc.sv
// ---------------------------------------------------------------------------
// tb_a2d_seq_mc
// Directed bench for a2d_seq_mc. dut_a: 4 slots, PACE 32, no averaging.
// dut_b: 1 slot, PACE 8, 4-sample averaging. Each has a small ADC model that
// echoes back 16'hA100+channel (dut_a) or a fixed sample list (dut_b).
// ---------------------------------------------------------------------------
module tb_a2d_seq_mc;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  a2d_seq_mc_if #(.NUM_CH(4), .RES_W(12)) bus_a ();
  a2d_seq_mc_if #(.NUM_CH(1), .RES_W(12)) bus_b ();

  a2d_seq_mc #(.NUM_CH(4), .CH_MAP({3'd4, 3'd3, 3'd1, 3'd0}), .RES_W(12),
               .PACE(32), .AVG_LOG2(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  a2d_seq_mc #(.NUM_CH(1), .CH_MAP(3'd0), .RES_W(12),
               .PACE(8), .AVG_LOG2(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model for dut_a: echo 16'hA100 + channel of the last full command
  logic        ss_p_a   = 1'b1;
  logic        sclk_p_a = 1'b0;
  logic [15:0] tx_a     = 16'h0000;
  logic [15:0] rx_a     = 16'h0000;
  int          bits_a   = 0;
  int          txn_a    = 0;
  logic [2:0]  last_ch_a = 3'd0;
  logic [15:0] cmd_q_a[$];

  always @(negedge clk) begin
    if (ss_p_a && !bus_a.SS_n) begin
      tx_a       = 16'hA100 + {13'd0, last_ch_a};
      bus_a.MISO = tx_a[15];
      bits_a     = 0;
      rx_a       = 16'h0000;
      txn_a++;
    end else if (!bus_a.SS_n && !sclk_p_a && bus_a.SCLK) begin
      rx_a = {rx_a[14:0], bus_a.MOSI};
      bits_a++;
    end else if (!bus_a.SS_n && sclk_p_a && !bus_a.SCLK) begin
      tx_a       = {tx_a[14:0], 1'b0};
      bus_a.MISO = tx_a[15];
    end else if (!ss_p_a && bus_a.SS_n) begin
      if (bits_a == 16) begin
        cmd_q_a.push_back(rx_a);
        last_ch_a = rx_a[13:11];
      end
    end
    ss_p_a   = bus_a.SS_n;
    sclk_p_a = bus_a.SCLK;
  end

  // ADC model for dut_b: every second transaction returns the next sample
  logic [15:0] avg_samp [4] = '{16'd10, 16'd20, 16'd30, 16'd41};
  logic        ss_p_b   = 1'b1;
  logic        sclk_p_b = 1'b0;
  logic [15:0] tx_b     = 16'h0000;
  int          txn_b    = 0;
  int          rd_idx_b = 0;

  always @(negedge clk) begin
    if (ss_p_b && !bus_b.SS_n) begin
      txn_b++;
      if ((txn_b % 2) == 0) begin
        tx_b = (rd_idx_b < 4) ? avg_samp[rd_idx_b] : 16'h0000;
        rd_idx_b++;
      end else begin
        tx_b = 16'h0FFF;
      end
      bus_b.MISO = tx_b[15];
    end else if (!bus_b.SS_n && sclk_p_b && !bus_b.SCLK) begin
      tx_b       = {tx_b[14:0], 1'b0};
      bus_b.MISO = tx_b[15];
    end
    ss_p_b   = bus_b.SS_n;
    sclk_p_b = bus_b.SCLK;
  end

  typedef struct {
    logic [3:0]  mask;
    int          slot;
    logic [11:0] res;
    logic        sweep;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] exp_cmd [8] = '{16'h0000, 16'h0000, 16'h0800, 16'h0800,
                               16'h1800, 16'h1800, 16'h2000, 16'h2000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_pub_a(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (bus_a.res_vld != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ss(input logic lvl, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (bus_a.SS_n == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // wait for a publish on dut_a and compare slot strobe, value and sweep_done
  task automatic expect_pub(input string name, input int slot, input logic [11:0] res,
                            input logic sweep);
    logic       ok;
    logic [3:0] e_vld;
    wait_pub_a(ok);
    check({name, "_timeout"}, {31'd0, ok}, 32'd1);
    e_vld = 4'b0001 << slot;
    check({name, "_vld"}, {28'd0, bus_a.res_vld}, {28'd0, e_vld});
    check({name, "_res"}, {20'd0, bus_a.result[12*slot +: 12]}, {20'd0, res});
    check({name, "_sweep"}, {31'd0, bus_a.sweep_done}, {31'd0, sweep});
  endtask

  initial begin
    logic ok;
    int   low_cnt;
    int   busy_cnt;
    int   txn_snap;

    vecs[0] = '{4'h5, 0, 12'h100, 1'b0};
    vecs[1] = '{4'h5, 2, 12'h103, 1'b1};
    vecs[2] = '{4'h5, 0, 12'h100, 1'b0};
    vecs[3] = '{4'h5, 2, 12'h103, 1'b1};
    vecs[4] = '{4'hF, 0, 12'h100, 1'b0};
    vecs[5] = '{4'hF, 1, 12'h101, 1'b0};
    vecs[6] = '{4'hF, 2, 12'h103, 1'b0};
    vecs[7] = '{4'hF, 3, 12'h104, 1'b1};

    rst_n         = 1'b0;
    bus_a.en      = 1'b0;
    bus_a.ch_mask = 4'h0;
    bus_b.en      = 1'b0;
    bus_b.ch_mask = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus_a.busy}, 32'd0);
    check("rst_result", bus_a.result[31:0], 32'd0);
    check("rst_res_vld", {28'd0, bus_a.res_vld}, 32'd0);
    check("rst_sweep", {31'd0, bus_a.sweep_done}, 32'd0);
    check("rst_ss_n", {31'd0, bus_a.SS_n}, 32'd1);
    rst_n = 1'b1;

    // table-driven sweeps: mask 0101 then mask 1111
    for (int v = 0; v < 8; v++) begin
      bus_a.ch_mask = vecs[v].mask;
      bus_a.en      = 1'b1;
      if (v == 4) begin
        cmd_q_a.delete();
      end
      expect_pub($sformatf("vec%0d", v), vecs[v].slot, vecs[v].res, vecs[v].sweep);
      @(negedge clk);
      check($sformatf("vec%0d_pulse", v), {28'd0, bus_a.res_vld}, 32'd0);
      if (v == 3) begin
        check("masked_slot1", {20'd0, bus_a.result[23:12]}, 32'd0);
        check("masked_slot3", {20'd0, bus_a.result[47:36]}, 32'd0);
      end
    end

    // command words for the full mask-1111 sweep
    check("cmd_count", cmd_q_a.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < cmd_q_a.size()) begin
        check($sformatf("cmd%0d", i), {16'd0, cmd_q_a[i]}, {16'd0, exp_cmd[i]});
      end else begin
        check($sformatf("cmd%0d_missing", i), 32'd0, 32'd1);
      end
    end

    // empty mask: in-flight slot 0 completes, then idle
    bus_a.ch_mask = 4'h0;
    expect_pub("mask0", 0, 12'h100, 1'b0);
    check("mask0_busy", {31'd0, bus_a.busy}, 32'd0);
    low_cnt  = 0;
    busy_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (!bus_a.SS_n) low_cnt++;
      if (bus_a.busy) busy_cnt++;
    end
    check("mask0_ss_idle", low_cnt, 32'd0);
    check("mask0_busy_idle", busy_cnt, 32'd0);

    // en dropped during PACE2 of slot 1
    bus_a.ch_mask = 4'hF;
    wait_ss(1'b0, ok);
    check("endrop_cmd_start", {31'd0, ok}, 32'd1);
    wait_ss(1'b1, ok);
    check("endrop_cmd_end", {31'd0, ok}, 32'd1);
    repeat (5) @(negedge clk);
    bus_a.en = 1'b0;
    expect_pub("endrop", 1, 12'h101, 1'b0);
    check("endrop_busy", {31'd0, bus_a.busy}, 32'd0);
    txn_snap = txn_a;
    low_cnt  = 0;
    repeat (300) begin
      @(negedge clk);
      if (!bus_a.SS_n) low_cnt++;
    end
    check("endrop_ss_idle", low_cnt, 32'd0);
    check("endrop_txn", txn_a, txn_snap);
    bus_a.en = 1'b1;
    expect_pub("resume", 2, 12'h103, 1'b0);

    // async reset in the middle of slot 3's RD transaction
    wait_ss(1'b0, ok);
    wait_ss(1'b1, ok);
    wait_ss(1'b0, ok);
    check("rd_start", {31'd0, ok}, 32'd1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ss_n", {31'd0, bus_a.SS_n}, 32'd1);
    check("arst_busy", {31'd0, bus_a.busy}, 32'd0);
    check("arst_result", {16'd0, bus_a.result[47:32]}, 32'd0);
    check("arst_res_vld", {28'd0, bus_a.res_vld}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_pub("restart", 0, 12'h100, 1'b0);
    check("restart_slot2_clr", {20'd0, bus_a.result[35:24]}, 32'd0);

    // averaging: four samples 10,20,30,41 -> one publish of 25
    bus_b.en = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus_b.res_vld != 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("avg_timeout", {31'd0, ok}, 32'd1);
    check("avg_samples_before_pub", rd_idx_b, 32'd4);
    check("avg_result", {20'd0, bus_b.result}, 32'd25);
    check("avg_sweep", {31'd0, bus_b.sweep_done}, 32'd1);
    bus_b.en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/a2d_seq_mc.md
Name: a2d_seq_mc

Overview:
Parametrised multi-channel A2D conversion sequencer. It round-robins over a configurable set of ADC channel slots through the team's SPI_mstr block, optionally averages 2^AVG_LOG2 samples per slot, and publishes per-slot results with valid strobes. Successor to the fixed four-channel A2D interface; adds a run-time channel-enable mask, run/stop control, averaging and status outputs.

Parameters:
NUM_CH, 4, number of channel slots (1..8)
CH_MAP, {3'd4,3'd3,3'd1,3'd0}, packed 3-bit ADC channel per slot; slot i = CH_MAP[3i+2:3i]
RES_W, 12, result width taken from rd_data[RES_W-1:0]
PACE, 16383, idle clocks before each SPI transaction (>=1)
AVG_LOG2, 0, log2 of samples averaged per published result (0..3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; level-sensitive
ch_mask  in  NUM_CH  slot enable mask, bit i enables slot i
MISO  in  1  SPI data from ADC
SS_n  out  1  SPI slave select, from SPI_mstr
SCLK  out  1  SPI clock, from SPI_mstr
MOSI  out  1  SPI data to ADC, from SPI_mstr
result  out  NUM_CH*RES_W  packed results, slot i = result[RES_W*i +: RES_W]
res_vld  out  NUM_CH  one-cycle pulse per slot when its result updates
sweep_done  out  1  one-cycle pulse when the last enabled slot of a sweep updates
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock clk; rst_n asynchronous active-low. Reset: result=0, res_vld=0, sweep_done=0, busy=0, all accumulators/sample counters=0, slot pointer=0, state=IDLE. SPI_mstr shares clk/rst_n.
- SPI command per slot: {2'b00, CH_MAP slot, 11'h000}. Each conversion is two transactions with the same command: first (CMD) result discarded, second (RD) returns sample = rd_data[RES_W-1:0].
- States: IDLE, PACE1, CMD, PACE2, RD, ACC.
  - IDLE: if en && |ch_mask -> select first enabled slot at or after pointer (wrapping), load pace counter, -> PACE1. Else stay.
  - PACE1: count PACE clocks; at terminal count pulse wrt for one clock -> CMD.
  - CMD: wait for done -> load pace counter -> PACE2.
  - PACE2: count PACE clocks; pulse wrt -> RD.
  - RD: wait for done; capture sample -> ACC.
  - ACC (1 clock): acc[slot] += sample (width RES_W+AVG_LOG2); samp_cnt[slot]++. If samp_cnt wraps to 0 (2^AVG_LOG2 samples reached): result[slot] <= (acc+sample)>>AVG_LOG2, acc cleared, res_vld[slot] pulses the following cycle. Advance pointer to next enabled slot (mask sampled here, wrapping). If the next enabled index <= current slot (wrap), sweep_done pulses with that res_vld (or on wrap alone if no result published when AVG_LOG2>0 — pulse only on a publishing wrap). Then: en && |ch_mask -> PACE1 with next slot; else -> IDLE.
- wrt never asserted outside PACE1/PACE2 terminal clocks; exactly one wrt per transaction.
- en deasserted mid-conversion: current conversion completes (through ACC), then IDLE; no SPI transaction aborted.
- ch_mask changes: only sampled in IDLE and ACC; in-flight slot completes even if its bit cleared. ch_mask=0 in ACC -> IDLE.
- Disabled slot: result holds last value; accumulator and samp_cnt hold partial state.
- Single enabled slot: converts repeatedly; sweep_done pulses on every publish.
- Accumulator cannot overflow: width RES_W+AVG_LOG2 holds 2^AVG_LOG2 full-scale samples.
- Async reset mid-transaction: all state cleared immediately; SS_n returns high via SPI_mstr reset.
- Latency from IDLE exit to res_vld (AVG_LOG2=0): 2*(PACE+1) + two SPI transaction times + 2 clocks.

Test Plan:
- NUM_CH=4, PACE=32, AVG_LOG2=0, mask=4'hF, ADC model returns 12'h100+ch -> results slots 0..3 = 12'h100,12'h101,12'h103,12'h104 in order; res_vld pulses 0,1,2,3; sweep_done with slot-3 pulse.
- Command check: monitor MOSI for each transaction -> two commands per slot, 16'h0000,0800,1800,2000 in sweep order; exactly 8 wrt per sweep.
- mask=4'b0101 -> only slots 0 and 2 converted, alternating; slots 1,3 results stay 0; sweep_done each slot-2 publish. mask=0 -> busy falls after current ACC.
- AVG_LOG2=2, slot 0 samples 10,20,30,41 -> single res_vld[0] after 4th conversion, result=25 (101>>2); no res_vld after samples 1-3.
- en dropped during PACE2 of slot 1 -> slot 1 still publishes, then busy=0, no further SS_n activity; en re-raised -> resumes at slot 2.
- rst_n asserted during RD transaction -> all outputs 0 asynchronously, SS_n=1; after release with en=1 restart at slot 0.
